fp_add_subt_unit: RTL
=====================

# fp_add_subt_unit

Multi-cycle IEEE-754 floating-point adder/subtractor for the CORDIC datapath. It sits on the responder side of the add/subtract handshake (`beg_add_subt`, `ack_add_subt`, `ready_add_subt`, `op_add_subt`, operands A/B, `result_add_subt`) that `CORDIC_Coprocessor` drives. It performs every X/Y/Z update of each CORDIC iteration. Each operation has fixed latency and is held until acknowledged.

## Interface
- `W`, 32: word width; 32/8 and 64/11 are the supported (`W`, `E`) pairs.
- `E`, 8: exponent width; mantissa width is `M = W-E-1`.
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `beg_add_subt`  in  1  start request; sampled only in IDLE.
- `ack_add_subt`  in  1  result consumed; sampled only in DONE.
- `op_add_subt`  in  1  0 = A+B, 1 = A−B; captured with `beg_add_subt`.
- `add_subt_dataA`  in  W  operand A; captured with `beg_add_subt`.
- `add_subt_dataB`  in  W  operand B; captured with `beg_add_subt`.
- `ready_add_subt`  out  1  result valid; registered.
- `result_add_subt`  out  W  result; registered, stable while ready.

## Operation
- Operands are captured on the IDLE edge where `beg_add_subt`=1. Subtract is implemented by inverting the captured sign of B.
- **Unpack:**
  - Biased exponent 0 is treated as zero: denormals flush to zero.
  - Otherwise the hidden 1 is prepended. Mantissa plus guard/round/sticky is `M+4` bits.
- **Specials:** if either exponent is all-ones (Inf/NaN), the result is quiet NaN (`7FC00000` / `7FF8000000000000`). This path still takes the full latency.
- **ALIGN:**
  - Swap operands so the first has the larger magnitude.
  - Right-shift the smaller mantissa by the exponent difference. Shifted-out bits OR into sticky.
  - A difference ≥ M+3 leaves only sticky.
- **ADD:** add the mantissas if the effective signs are equal, otherwise subtract them (larger − smaller). The result sign is the larger operand's sign.
- **NORM:**
  - On carry-out, shift right 1 and increment the exponent.
  - Otherwise left-shift by the leading-zero count, using a combinational LZC (single cycle), and decrement the exponent.
  - Underflow to exponent ≤ 0 flushes to zero.
- **ROUND:**
  - Round to nearest, ties to even.
  - A mantissa carry on rounding increments the exponent.
  - An exponent reaching all-ones saturates to ±Inf.
  - An exact zero result is +0.
- **FSM:** IDLE →(beg) ALIGN → ADD → NORM → ROUND → DONE →(ack) IDLE. `rst` forces IDLE from any state.

## Timing
- **Reset values:** state IDLE, `ready_add_subt`=0, `result_add_subt`=0, internal registers 0.
- **Latency:** `ready_add_subt` rises exactly 5 clock edges after the edge that sampled `beg_add_subt`. `result_add_subt` is updated on that same edge.
- **Ready hold:** `ready_add_subt` stays high, with the result frozen, for as long as `ack_add_subt`=0.
- **Ack release:** on the first DONE edge with ack=1, the block goes to IDLE and `ready_add_subt`=0 the next cycle. `result_add_subt` keeps its value until the next capture.
- **Ignored inputs:**
  - `beg_add_subt` is ignored in every state except IDLE.
  - `ack_add_subt` is ignored in every state except DONE.
  - Operand/op changes after capture have no effect.
- **beg and ack together in DONE:** only the ack is honoured. beg must still be high in IDLE to start a new operation, so back-to-back operations have a minimum of 7 cycles beg-to-beg.
- **Reset mid-operation:** asynchronous return to IDLE. ready=0 and result=0 immediately; the in-flight operation is discarded.

## Structure
- Package `fp_add_subt_pkg`:
  - state encoding (IDLE, ALIGN, ADD, NORM, ROUND, DONE);
  - QNaN constants for 32/64;
  - bias = 2^(E−1)−1;
  - GRS width (3).
- Sub-module `leading_zero_counter`: parameterised width, combinational, count output `$clog2(M+5)` bits.
- Top level holds the FSM, pipeline registers and rounding logic.

## Test plan
- **Basic add:** A=3F800000, B=3F800000, op=0 → result 40000000, ready exactly 5 edges after the beg edge. A=3F800000, B=3F800000, op=1 → 00000000.
- **Sticky/rounding:**
  - 3F800000 + 30800000 (2^-30) → 3F800000;
  - 3F800000 + 33800000 (tie) → 3F800000;
  - 3F800000 + 33C00000 → 3F800001.
- **Cancellation/normalisation:** 3F800001 − 3F800000 → 34000000 (2^-23); sign check: 3F800000 − 40000000 → BF800000.
- **Overflow and specials:**
  - 7F7FFFFF + 7F7FFFFF → 7F800000;
  - 7F800000 + 3F800000 → 7FC00000;
  - 00000001 (denormal) + 00000000 → 00000000.
- **Handshake:**
  - ack held low 10 cycles → ready and result stable throughout;
  - beg pulsed during ALIGN/NORM → ignored;
  - beg and ack both high in DONE → return to IDLE, no new capture.
- **Reset mid-op:** assert `rst` during ADD → ready=0 and result=0 asynchronously; the next beg (3F800000+3F800000) completes normally with 40000000.

Source files
------------

// File: rtl/fp_add_subt_pkg.sv
// ============================================================================
// Module      : fp_add_subt_pkg
// Description : Shared state encoding and constants for the FP add/sub unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_add_subt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_ADD   = 3'd2,
    ST_NORM  = 3'd3,
    ST_ROUND = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam int GRS_W = 3;

  localparam logic [31:0] QNAN_32 = 32'h7FC0_0000;
  localparam logic [63:0] QNAN_64 = 64'h7FF8_0000_0000_0000;

  function automatic int exp_bias(input int e);
    return (1 << (e - 1)) - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_add_subt_if.sv
// ============================================================================
// Module      : fp_add_subt_if
// Description : Start/acknowledge handshake between the CORDIC sequencer and
//               the floating-point add/subtract unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fp_add_subt_if #(
  parameter int W = 32
);
  import fp_add_subt_pkg::*;

  logic         beg_add_subt;
  logic         ack_add_subt;
  logic         op_add_subt;
  logic [W-1:0] add_subt_dataA;
  logic [W-1:0] add_subt_dataB;
  logic         ready_add_subt;
  logic [W-1:0] result_add_subt;

  modport master (
    output beg_add_subt, ack_add_subt, op_add_subt, add_subt_dataA, add_subt_dataB,
    input  ready_add_subt, result_add_subt
  );

  modport slave (
    input  beg_add_subt, ack_add_subt, op_add_subt, add_subt_dataA, add_subt_dataB,
    output ready_add_subt, result_add_subt
  );

endinterface

`default_nettype wire

// File: rtl/fp_add_subt_unit_lzc.sv
// ============================================================================
// Module      : leading_zero_counter
// Description : Combinational leading-zero count; an all-zero input gives WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module leading_zero_counter #(
  parameter int WIDTH = 28,
  parameter int CW    = $clog2(WIDTH)
) (
  input  wire logic [WIDTH-1:0] value,
  output logic      [CW-1:0]    count
);

  // Scanning upward lets the highest set bit make the final assignment.
  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_add_subt_unit.sv
// ============================================================================
// Module      : fp_add_subt_unit
// Description : Multi-cycle IEEE-754 adder/subtractor, round-to-nearest-even,
//               denormals flushed to zero, result held until acknowledged.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_add_subt_unit
  import fp_add_subt_pkg::*;
#(
  parameter int W = 32,
  parameter int E = 8
) (
  input wire logic     clk,
  input wire logic     rst,
  fp_add_subt_if.slave bus
);

  localparam int M  = W - E - 1;
  localparam int MW = M + 1 + GRS_W;
  localparam int SW = MW + 1;
  localparam int XW = E + 2;
  localparam int CW = $clog2(SW);

  localparam logic [W-1:0]         c_qnan    = (W == 64) ? W'(QNAN_64) : W'(QNAN_32);
  localparam logic signed [XW-1:0] c_exp_max = XW'((1 << E) - 1);

  state_t                r_state;
  logic [W-1:0]          r_a, r_b, r_rounded, r_result;
  logic                  r_op, r_ready;
  logic                  r_sign, r_eff_sub, r_special, r_zero;
  logic [E-1:0]          r_exp;
  logic [MW-1:0]         r_mant_big, r_mant_small, r_norm_mant;
  logic [SW-1:0]         r_sum;
  logic signed [XW-1:0]  r_norm_exp;

  // ---------------- unpack / align ----------------
  logic [E-1:0]   w_exp_a, w_exp_b, w_exp_big, w_exp_small, w_diff;
  logic [M:0]     w_sig_a, w_sig_b, w_sig_big, w_sig_small;
  logic           w_sign_a, w_sign_b, w_sign_big, w_a_big;
  logic [MW-1:0]  w_ext_small, w_aligned;
  logic [2*MW-1:0] w_shift_full;

  always_comb begin
    w_exp_a  = r_a[W-2:M];
    w_exp_b  = r_b[W-2:M];
    w_sign_a = r_a[W-1];
    w_sign_b = r_b[W-1] ^ r_op;
    w_sig_a  = (w_exp_a == '0) ? '0 : {1'b1, r_a[M-1:0]};
    w_sig_b  = (w_exp_b == '0) ? '0 : {1'b1, r_b[M-1:0]};
    w_a_big  = {w_exp_a, w_sig_a} >= {w_exp_b, w_sig_b};

    w_sign_big  = w_a_big ? w_sign_a : w_sign_b;
    w_exp_big   = w_a_big ? w_exp_a  : w_exp_b;
    w_exp_small = w_a_big ? w_exp_b  : w_exp_a;
    w_sig_big   = w_a_big ? w_sig_a  : w_sig_b;
    w_sig_small = w_a_big ? w_sig_b  : w_sig_a;
    w_diff      = w_exp_big - w_exp_small;

    w_ext_small  = {w_sig_small, {GRS_W{1'b0}}};
    w_shift_full = {w_ext_small, {MW{1'b0}}} >> w_diff;
    if (w_diff >= E'(M + 3)) begin
      w_aligned = {{(MW-1){1'b0}}, |w_sig_small};
    end else begin
      w_aligned = {w_shift_full[2*MW-1:MW+1], w_shift_full[MW] | (|w_shift_full[MW-1:0])};
    end
  end

  // ---------------- normalise ----------------
  logic [CW-1:0]        w_lzc, w_lshift;
  logic signed [XW-1:0] w_exp_big_s, w_exp_norm;
  logic [MW-1:0]        w_mant_norm;

  leading_zero_counter #(.WIDTH(SW), .CW(CW)) u_lzc (
    .value (r_sum),
    .count (w_lzc)
  );

  always_comb begin
    w_exp_big_s = $signed({2'b00, r_exp});
    w_lshift    = w_lzc - CW'(1);
    if (r_sum[SW-1]) begin
      // Carry-out: keep the dropped LSB alive in sticky.
      w_mant_norm = {r_sum[SW-1:2], r_sum[1] | r_sum[0]};
      w_exp_norm  = w_exp_big_s + $signed(XW'(1));
    end else begin
      w_mant_norm = r_sum[MW-1:0] << w_lshift;
      w_exp_norm  = w_exp_big_s - $signed({{(XW-CW){1'b0}}, w_lshift});
    end
  end

  // ---------------- round ----------------
  logic                 w_round_up;
  logic [M+1:0]         w_rounded;
  logic signed [XW-1:0] w_exp_round;
  logic [M-1:0]         w_frac;
  logic [W-1:0]         w_round_result;

  always_comb begin
    w_round_up  = r_norm_mant[2] & (r_norm_mant[1] | r_norm_mant[0] | r_norm_mant[3]);
    w_rounded   = {1'b0, r_norm_mant[MW-1:GRS_W]} + (M+2)'(w_round_up);
    w_exp_round = r_norm_exp + $signed({{(XW-1){1'b0}}, w_rounded[M+1]});
    w_frac      = w_rounded[M+1] ? w_rounded[M:1] : w_rounded[M-1:0];
    if (r_special) begin
      w_round_result = c_qnan;
    end else if (r_zero) begin
      w_round_result = '0;
    end else if (w_exp_round >= c_exp_max) begin
      w_round_result = {r_sign, {E{1'b1}}, {M{1'b0}}};
    end else begin
      w_round_result = {r_sign, w_exp_round[E-1:0], w_frac};
    end
  end

  // ---------------- control and pipeline registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= 1'b0;
      r_sign       <= 1'b0;
      r_eff_sub    <= 1'b0;
      r_special    <= 1'b0;
      r_zero       <= 1'b0;
      r_exp        <= '0;
      r_mant_big   <= '0;
      r_mant_small <= '0;
      r_sum        <= '0;
      r_norm_mant  <= '0;
      r_norm_exp   <= '0;
      r_rounded    <= '0;
      r_result     <= '0;
      r_ready      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.beg_add_subt) begin
            r_a     <= bus.add_subt_dataA;
            r_b     <= bus.add_subt_dataB;
            r_op    <= bus.op_add_subt;
            r_state <= ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          r_sign       <= w_sign_big;
          r_exp        <= w_exp_big;
          r_mant_big   <= {w_sig_big, {GRS_W{1'b0}}};
          r_mant_small <= w_aligned;
          r_eff_sub    <= w_sign_a ^ w_sign_b;
          r_special    <= (&w_exp_a) | (&w_exp_b);
          r_state      <= ST_ADD;
        end
        ST_ADD: begin
          r_sum   <= r_eff_sub ? ({1'b0, r_mant_big} - {1'b0, r_mant_small})
                               : ({1'b0, r_mant_big} + {1'b0, r_mant_small});
          r_state <= ST_NORM;
        end
        ST_NORM: begin
          r_norm_mant <= w_mant_norm;
          r_norm_exp  <= w_exp_norm;
          r_zero      <= (r_sum == '0) || w_exp_norm[XW-1] || (w_exp_norm == '0);
          r_state     <= ST_ROUND;
        end
        ST_ROUND: begin
          r_rounded <= w_round_result;
          r_state   <= ST_DONE;
        end
        ST_DONE: begin
          // The first DONE edge publishes the result; ack counts once it is visible.
          if (!r_ready) begin
            r_ready  <= 1'b1;
            r_result <= r_rounded;
          end else if (bus.ack_add_subt) begin
            r_ready <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready_add_subt  = r_ready;
  assign bus.result_add_subt = r_result;

endmodule

`default_nettype wire
